// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - Avalon-MM programmable raster timing generator with tear-free shadow timing
`timescale 1ns/1ps
module video_timing_gen #(
  parameter int COORD_W      = 12,
  parameter int H_ACTIVE_RST = 640,
  parameter int H_TOTAL_RST  = 800,
  parameter int HS_START_RST = 656,
  parameter int HS_END_RST   = 752,
  parameter int V_ACTIVE_RST = 480,
  parameter int V_TOTAL_RST  = 525,
  parameter int VS_START_RST = 490,
  parameter int VS_END_RST   = 492,
  parameter bit ENABLE_RST   = 1'b1
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [2:0]         avs_address,
  input  logic [31:0]        avs_writedata,
  output logic [31:0]        avs_readdata,
  output logic               irq,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               frame_start
);

  // Control bits (live; polarities act immediately, enable gates counting)
  logic ctrl_enable;
  logic ctrl_hs_pol;
  logic ctrl_vs_pol;
  logic ctrl_irq_en;

  // Live timing set, written by the CPU at any time
  logic [COORD_W-1:0] h_active, h_total, hs_start, hs_end;
  logic [COORD_W-1:0] v_active, v_total, vs_start, vs_end;

  // Shadow timing set, the one the counters and decode actually use
  logic [COORD_W-1:0] sh_h_active, sh_h_total, sh_hs_start, sh_hs_end;
  logic [COORD_W-1:0] sh_v_active, sh_v_total, sh_vs_start, sh_vs_end;

  logic [COORD_W-1:0] cx, cy;
  logic               frame_done;
  logic               cfg_err;

  logic [COORD_W-1:0] wd_lo, wd_hi;
  logic               wr_ctrl, wr_status;
  logic               last_x, last_y, wrap, en_rise, load_req, live_bad;
  logic               at_origin, h_win, v_win, in_vblank;
  logic [31:0]        rd_mux;
  logic               unused_wdata;

  // Register fields are 16 bits wide on the bus; only COORD_W bits are kept
  assign wd_lo        = avs_writedata[COORD_W-1:0];
  assign wd_hi        = avs_writedata[16 +: COORD_W];
  assign unused_wdata = ^avs_writedata;

  assign wr_ctrl   = avs_write && (avs_address == 3'd0);
  assign wr_status = avs_write && (avs_address == 3'd5);

  assign last_x    = (cx == sh_h_total - 1'b1);
  assign last_y    = (cy == sh_v_total - 1'b1);
  assign wrap      = ctrl_enable && last_x && last_y;
  // Enabling from idle restarts at (0,0), so it is also a frame boundary
  assign en_rise   = wr_ctrl && avs_writedata[0] && !ctrl_enable;
  assign load_req  = wrap || en_rise;
  assign live_bad  = (h_total < COORD_W'(2)) || (v_total < COORD_W'(2));

  assign at_origin = (cx == '0) && (cy == '0);
  assign h_win     = (cx >= sh_hs_start) && (cx < sh_hs_end);
  assign v_win     = (cy >= sh_vs_start) && (cy < sh_vs_end);
  assign in_vblank = (cy >= sh_v_active);

  assign irq = frame_done && ctrl_irq_en;

  // CPU writes to the live control and timing registers
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      ctrl_enable <= ENABLE_RST;
      ctrl_hs_pol <= 1'b0;
      ctrl_vs_pol <= 1'b0;
      ctrl_irq_en <= 1'b0;
      h_active    <= COORD_W'(H_ACTIVE_RST);
      h_total     <= COORD_W'(H_TOTAL_RST);
      hs_start    <= COORD_W'(HS_START_RST);
      hs_end      <= COORD_W'(HS_END_RST);
      v_active    <= COORD_W'(V_ACTIVE_RST);
      v_total     <= COORD_W'(V_TOTAL_RST);
      vs_start    <= COORD_W'(VS_START_RST);
      vs_end      <= COORD_W'(VS_END_RST);
    end else if (avs_write) begin
      case (avs_address)
        3'd0: begin
          ctrl_enable <= avs_writedata[0];
          ctrl_hs_pol <= avs_writedata[1];
          ctrl_vs_pol <= avs_writedata[2];
          ctrl_irq_en <= avs_writedata[3];
        end
        3'd1: begin h_active <= wd_lo; h_total <= wd_hi; end
        3'd2: begin hs_start <= wd_lo; hs_end  <= wd_hi; end
        3'd3: begin v_active <= wd_lo; v_total <= wd_hi; end
        3'd4: begin vs_start <= wd_lo; vs_end  <= wd_hi; end
        default: ;
      endcase
    end
  end

  // Copy live timing to shadow at frame boundaries; reject degenerate totals
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sh_h_active <= COORD_W'(H_ACTIVE_RST);
      sh_h_total  <= COORD_W'(H_TOTAL_RST);
      sh_hs_start <= COORD_W'(HS_START_RST);
      sh_hs_end   <= COORD_W'(HS_END_RST);
      sh_v_active <= COORD_W'(V_ACTIVE_RST);
      sh_v_total  <= COORD_W'(V_TOTAL_RST);
      sh_vs_start <= COORD_W'(VS_START_RST);
      sh_vs_end   <= COORD_W'(VS_END_RST);
      cfg_err     <= 1'b0;
    end else begin
      if (load_req && !live_bad) begin
        sh_h_active <= h_active;
        sh_h_total  <= h_total;
        sh_hs_start <= hs_start;
        sh_hs_end   <= hs_end;
        sh_v_active <= v_active;
        sh_v_total  <= v_total;
        sh_vs_start <= vs_start;
        sh_vs_end   <= vs_end;
      end
      if (load_req && live_bad)
        cfg_err <= 1'b1;
      else if (wr_status && avs_writedata[2])
        cfg_err <= 1'b0;
    end
  end

  // Sticky frame flag: a new frame beats a simultaneous write-1-to-clear
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n)
      frame_done <= 1'b0;
    else if (ctrl_enable && at_origin)
      frame_done <= 1'b1;
    else if (wr_status && avs_writedata[1])
      frame_done <= 1'b0;
  end

  // Raster counters; held at the origin while disabled
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || !ctrl_enable) begin
      cx <= '0;
      cy <= '0;
    end else if (last_x) begin
      cx <= '0;
      cy <= last_y ? '0 : cy + 1'b1;
    end else begin
      cx <= cx + 1'b1;
    end
  end

  // Registered decode of the counters into sync, enable and coordinates
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else if (ctrl_enable) begin
      hsync       <= h_win ? ctrl_hs_pol : ~ctrl_hs_pol;
      vsync       <= v_win ? ctrl_vs_pol : ~ctrl_vs_pol;
      de          <= (cx < sh_h_active) && (cy < sh_v_active);
      pix_x       <= cx;
      pix_y       <= cy;
      frame_start <= at_origin;
    end else begin
      hsync       <= ~ctrl_hs_pol;
      vsync       <= ~ctrl_vs_pol;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end
  end

  // Read multiplexer over the register map
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0: rd_mux = {28'd0, ctrl_irq_en, ctrl_vs_pol, ctrl_hs_pol, ctrl_enable};
      3'd1: rd_mux = {16'(h_total), 16'(h_active)};
      3'd2: rd_mux = {16'(hs_end), 16'(hs_start)};
      3'd3: rd_mux = {16'(v_total), 16'(v_active)};
      3'd4: rd_mux = {16'(vs_end), 16'(vs_start)};
      3'd5: rd_mux = {16'(cy), 13'd0, cfg_err, frame_done, in_vblank};
      default: rd_mux = '0;
    endcase
  end

  // Read data captured one cycle after the strobe and held until the next read
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n)
      avs_readdata <= '0;
    else if (avs_read)
      avs_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen against an arithmetic raster model
`timescale 1ns/1ps
module tb_video_timing_gen;

  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          resetn;
  logic          avs_read, avs_write;
  logic [2:0]    avs_address;
  logic [31:0]   avs_writedata, avs_readdata;
  logic          irq, hsync, vsync, de, frame_start;
  logic [CW-1:0] pix_x, pix_y;
  logic [27:0]   obs;

  video_timing_gen #(.COORD_W(CW)) dut (
    .clk_clk       (clk),
    .reset_reset_n (resetn),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_address   (avs_address),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .hsync         (hsync),
    .vsync         (vsync),
    .de            (de),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .frame_start   (frame_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {hsync, vsync, de, frame_start, pix_x, pix_y};

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int ht, ha, hss, hse, vt, va, vss, vse;
    bit hpol, vpol;
  } mode_t;

  mode_t cur, dflt, m_a;
  int    t0;

  // Expected outputs at frame position p: position splits into line and column
  function automatic logic [27:0] model(input mode_t m, input int p);
    int x, y;
    bit hact, vact;
    x    = p % m.ht;
    y    = (p / m.ht) % m.vt;
    hact = (x >= m.hss) && (x < m.hse);
    vact = (y >= m.vss) && (y < m.vse);
    return {hact ? m.hpol : ~m.hpol, vact ? m.vpol : ~m.vpol,
            (x < m.ha) && (y < m.va), (x == 0) && (y == 0), 12'(x), 12'(y)};
  endfunction

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] q);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    q = avs_readdata;
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [31:0] d, output logic [31:0] q);
    avs_address = a; avs_writedata = d; avs_read = 1'b1; avs_write = 1'b1;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
    q = avs_readdata;
  endtask

  task automatic prog_mode(input mode_t m);
    wr(3'd1, {16'(m.ht), 16'(m.ha)});
    wr(3'd2, {16'(m.hse), 16'(m.hss)});
    wr(3'd3, {16'(m.vt), 16'(m.va)});
    wr(3'd4, {16'(m.vse), 16'(m.vss)});
    wr(3'd0, {28'd0, 1'b0, m.vpol, m.hpol, 1'b0});
    wr(3'd0, {28'd0, 1'b0, m.vpol, m.hpol, 1'b1});
    cur = m;
    t0  = cyc + 1;
  endtask

  task automatic wait_phase(input int ph);
    int per;
    per = cur.ht * cur.vt;
    for (int i = 0; i <= per; i++) begin
      if ((cyc - t0) % per == ph) return;
      @(negedge clk);
    end
    n_checks++; n_fail++;
    $display("FAIL wait_phase: phase %0d not reached, at %0d", ph, (cyc - t0) % per);
  endtask

  task automatic test_reset;
    logic [27:0] exp;
    logic [31:0] q, qexp;
    logic [31:0] regs_exp [5];
    int e, y;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({obs, irq, avs_readdata} !== {4'b1100, 24'd0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h/%b/%h expected c000000/0/00000000", obs, irq, avs_readdata);
    end
    resetn = 1'b1; cur = dflt; t0 = cyc + 1;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      e = cyc - t0; exp = model(cur, e);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL default_raster pos %0d: got %h expected %h", e, obs, exp);
        break;
      end
    end
    regs_exp = '{32'h0000_0001, 32'h0320_0280, 32'h02F0_0290, 32'h020D_01E0, 32'h01EC_01EA};
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), q);
      n_checks++;
      if (q !== regs_exp[a]) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h expected %h", a, q, regs_exp[a]);
      end
    end
    e = cyc - t0;
    y = ((e + 1) % 420000) / 800;
    qexp = {16'(y), 13'd0, 1'b0, 1'b1, y >= 480};
    rd(3'd5, q);
    n_checks++;
    if (q !== qexp) begin
      n_fail++;
      $display("FAIL reset_status: got %h expected %h", q, qexp);
    end
  endtask

  task automatic test_random_modes;
    mode_t m;
    logic [27:0] exp;
    int e;
    for (int k = 0; k < 4; k++) begin
      m.ht   = int'($urandom_range(40, 4));
      m.ha   = int'($urandom_range(m.ht, 1));
      m.hss  = int'($urandom_range(m.ht - 1, 0));
      m.hse  = (k == 3) ? m.hss : int'($urandom_range(m.ht, 0));
      m.vt   = int'($urandom_range(10, 2));
      m.va   = int'($urandom_range(m.vt, 1));
      m.vss  = int'($urandom_range(m.vt - 1, 0));
      m.vse  = int'($urandom_range(m.vt, 0));
      m.hpol = 1'($urandom_range(1, 0));
      m.vpol = 1'($urandom_range(1, 0));
      prog_mode(m);
      for (int i = 0; i < 2 * m.ht * m.vt + 3; i++) begin
        @(negedge clk);
        e = cyc - t0; exp = model(cur, e);
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL random_mode%0d pos %0d: got %h expected %h", k, e, obs, exp);
          break;
        end
      end
    end
  endtask

  task automatic test_tear_free;
    mode_t mb;
    logic [27:0] exp;
    int e, pa, pb;
    prog_mode(m_a);
    mb = m_a; mb.ht = 100; mb.ha = 80; mb.vt = 10; mb.va = 8;
    pa = m_a.ht * m_a.vt; pb = mb.ht * mb.vt;
    repeat (31) @(negedge clk);
    wr(3'd1, 32'h0064_0050);
    wr(3'd3, 32'h000A_0008);
    while ((cyc - t0) < pa + 2 * pb + 2) begin
      @(negedge clk);
      e = cyc - t0;
      exp = (e < pa) ? model(m_a, e) : model(mb, e - pa);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL tear_free pos %0d: got %h expected %h", e, obs, exp);
        break;
      end
    end
    cur = mb; t0 = t0 + pa;
  endtask

  task automatic test_invalid_cfg;
    logic [27:0] exp;
    logic [31:0] q;
    int e, pa;
    prog_mode(m_a);
    pa = m_a.ht * m_a.vt;
    repeat (10) @(negedge clk);
    wr(3'd1, {16'd1, 16'd16});
    while ((cyc - t0) < 2 * pa + 5) begin
      @(negedge clk);
      e = cyc - t0; exp = model(m_a, e);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL invalid_keeps_timing pos %0d: got %h expected %h", e, obs, exp);
        break;
      end
    end
    rd(3'd5, q);
    n_checks++;
    if (q[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_err_set: got %b expected 1", q[2]);
    end
    wr(3'd5, 32'h4);
    rd(3'd5, q);
    n_checks++;
    if (q[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err_clear: got %b expected 0", q[2]);
    end
    wr(3'd1, {16'(m_a.ht), 16'(m_a.ha)});
  endtask

  task automatic test_interrupt;
    logic [31:0] q;
    logic exp_irq;
    int e, pa;
    pa = cur.ht * cur.vt;
    wr(3'd5, 32'h2);
    wr(3'd0, 32'h9);
    for (int i = 0; i <= pa; i++) begin
      e = cyc - t0; exp_irq = (e % pa == 0);
      n_checks++;
      if ({irq, frame_start} !== {exp_irq, exp_irq}) begin
        n_fail++;
        $display("FAIL irq_align pos %0d: got irq=%b fs=%b expected %b", e, irq, frame_start, exp_irq);
        break;
      end
      if (exp_irq) break;
      @(negedge clk);
    end
    wait_phase(pa - 1);
    wr(3'd5, 32'h2);
    n_checks++;
    if ({irq, frame_start} !== 2'b11) begin
      n_fail++;
      $display("FAIL irq_set_wins: got irq=%b fs=%b expected 1 1", irq, frame_start);
    end
    rd(3'd5, q);
    n_checks++;
    if (q[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_done_set_wins: got %b expected 1", q[1]);
    end
    wr(3'd5, 32'h2);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: got %b expected 0", irq);
    end
    wr(3'd0, 32'h1);
  endtask

  task automatic test_enable_toggle;
    logic [27:0] exp;
    int e, pa;
    pa = cur.ht * cur.vt;
    wait_phase(4);
    wr(3'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = {~cur.hpol, ~cur.vpol, 26'd0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL disabled_idle cycle %0d: got %h expected %h", i, obs, exp);
        break;
      end
    end
    wr(3'd0, 32'h1);
    t0 = cyc + 1;
    for (int i = 0; i < pa + 2; i++) begin
      @(negedge clk);
      e = cyc - t0; exp = model(cur, e);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reenable pos %0d: got %h expected %h", e, obs, exp);
        break;
      end
    end
  endtask

  task automatic test_polarity_readback;
    logic [27:0] exp;
    logic [31:0] q;
    int e;
    wr(3'd0, 32'h7);
    cur.hpol = 1'b1; cur.vpol = 1'b1;
    for (int i = 0; i < cur.ht * cur.vt; i++) begin
      @(negedge clk);
      e = cyc - t0; exp = model(cur, e);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL polarity pos %0d: got %h expected %h", e, obs, exp);
        break;
      end
    end
    wait_phase(3 * cur.ht + 5);
    rd(3'd5, q);
    n_checks++;
    if (q[31:16] !== 16'd3) begin
      n_fail++;
      $display("FAIL status_y: got %0d expected 3", q[31:16]);
    end
    rd(3'd6, q);
    n_checks++;
    if (q !== 32'd0) begin
      n_fail++;
      $display("FAIL addr6_read: got %h expected 0", q);
    end
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, q);
    n_checks++;
    if (q !== 32'd0) begin
      n_fail++;
      $display("FAIL addr7_read: got %h expected 0", q);
    end
    rdwr(3'd2, 32'h0012_0011, q);
    n_checks++;
    if (q !== 32'h0013_0011) begin
      n_fail++;
      $display("FAIL rdwr_old_value: got %h expected 00130011", q);
    end
    rd(3'd2, q);
    n_checks++;
    if (q !== 32'h0012_0011) begin
      n_fail++;
      $display("FAIL rdwr_new_value: got %h expected 00120011", q);
    end
    wr(3'd4, 32'hFFFF_FFFF);
    rd(3'd4, q);
    n_checks++;
    if (q !== 32'h0FFF_0FFF) begin
      n_fail++;
      $display("FAIL field_truncate: got %h expected 0fff0fff", q);
    end
  endtask

  task automatic test_reset_midframe;
    logic [27:0] exp;
    logic [31:0] q;
    int e;
    wait_phase(50);
    resetn = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({obs, irq, avs_readdata} !== {4'b1100, 24'd0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL midframe_reset: got %h/%b/%h expected c000000/0/00000000", obs, irq, avs_readdata);
    end
    resetn = 1'b1; cur = dflt; t0 = cyc + 1;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      e = cyc - t0; exp = model(cur, e);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL post_reset_raster pos %0d: got %h expected %h", e, obs, exp);
        break;
      end
    end
    rd(3'd0, q);
    n_checks++;
    if (q !== 32'h1) begin
      n_fail++;
      $display("FAIL post_reset_ctrl: got %h expected 00000001", q);
    end
    rd(3'd4, q);
    n_checks++;
    if (q !== 32'h01EC_01EA) begin
      n_fail++;
      $display("FAIL post_reset_vtim1: got %h expected 01ec01ea", q);
    end
  endtask

  initial begin
    resetn = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    avs_address = '0; avs_writedata = '0;
    dflt = '{800, 640, 656, 752, 525, 480, 490, 492, 1'b0, 1'b0};
    m_a  = '{20, 16, 17, 19, 6, 4, 5, 6, 1'b0, 1'b0};
    test_reset;
    test_random_modes;
    test_tear_free;
    test_invalid_cfg;
    test_interrupt;
    test_enable_toggle;
    test_polarity_readback;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
